// File: rtl/psg_cmd_writer.sv
// PSG command transmitter: encodes tone/attenuation requests into PSG bytes
// and drives Z80-style memory-write cycles to the PSG port.
module psg_cmd_writer #(
  parameter logic [7:0]  PORT_ADDR     = 8'h7F,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_atten,
  input  logic [1:0]  req_chan,
  input  logic [9:0]  req_freq,
  input  logic [3:0]  req_mag,
  output logic [15:0] addr,
  output logic        MREQ_N,
  output logic        WR_N,
  output logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [7:0]         byte2_q, byte2_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               mreq_n_q, wr_n_q, strobe_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept_c;
  logic [7:0]         byte1_c;

  assign req_ready = (state_q == IDLE) & ~reset;
  assign accept_c  = req_valid & req_ready;

  // First (or only) byte: latch bit, register {chan, atten}, low nibble of payload
  assign byte1_c = {1'b1, req_chan, req_atten, req_atten ? req_mag : req_freq[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      byte2_q  <= 8'h00;
      addr_q   <= 16'h0000;
      data_q   <= 8'h00;
      mreq_n_q <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      byte2_q  <= byte2_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mreq_n_q <= strobe_n_d;
      wr_n_q   <= strobe_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    byte2_d = byte2_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_chan == 2'd3) begin
            err_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = '0;
            addr_d  = {8'h00, PORT_ADDR};
            data_d  = byte1_c;
            pend_d  = ~req_atten;
            byte2_d = {2'b00, req_freq[9:4]};
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_W'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          // Second tone byte goes out through its own SETUP so data changes with strobes high
          if (pend_q) begin
            state_d = SETUP;
            pend_d  = 1'b0;
            data_d  = byte2_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the next state so they align with the state they describe
  assign strobe_n_d = (state_d != STROBE);
  assign busy_d     = (state_d != IDLE);
  assign done_d     = (state_d == DONE);

  assign addr   = addr_q;
  assign data   = data_q;
  assign MREQ_N = mreq_n_q;
  assign WR_N   = wr_n_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_psg_cmd_writer.sv
// Self-checking bench for psg_cmd_writer: bus monitor plus a byte-level
// reference model of the PSG encoding and write-cycle timing.
module tb_psg_cmd_writer;

  localparam int S = 2;
  localparam int G = 2;
  localparam int ATT_BUSY  = 1 + S + G + 1;
  localparam int TONE_BUSY = 2 * (1 + S + G) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_atten = 1'b0;
  logic [1:0]  req_chan = 2'd0;
  logic [9:0]  req_freq = 10'd0;
  logic [3:0]  req_mag = 4'd0;
  logic [15:0] addr;
  logic        MREQ_N, WR_N;
  logic [7:0]  data;
  logic        busy, done, err;

  int total = 0;
  int bad = 0;

  // Monitor state
  logic [7:0] bytes_q[$];
  int         lens_q[$];
  int         gaps_q[$];
  int         busy_total = 0, done_total = 0, err_total = 0;
  int         stable_bad = 0, overlap_total = 0;

  psg_cmd_writer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_atten(req_atten), .req_chan(req_chan), .req_freq(req_freq), .req_mag(req_mag),
    .addr(addr), .MREQ_N(MREQ_N), .WR_N(WR_N), .data(data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Bus monitor: records strobed bytes, strobe lengths and high gaps between strobes
  initial begin
    int low_run, hi_run;
    bit have_prev;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    low_run = 0; hi_run = 0; have_prev = 0; s_addr = '0; s_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        low_run = 0; hi_run = 0; have_prev = 0;
      end else begin
        if (busy) busy_total++;
        if (busy && req_ready) overlap_total++;
        if (done) done_total++;
        if (err) err_total++;
        if (MREQ_N !== WR_N) stable_bad++;
        if (MREQ_N === 1'b0) begin
          if (low_run == 0) begin
            bytes_q.push_back(data);
            gaps_q.push_back(have_prev ? hi_run : -1);
            s_addr = addr; s_data = data;
          end else if (addr !== s_addr || data !== s_data) begin
            stable_bad++;
          end
          if (addr !== 16'h007F) stable_bad++;
          low_run++;
        end else begin
          if (low_run != 0) begin
            lens_q.push_back(low_run);
            have_prev = 1; hi_run = 0;
          end
          low_run = 0;
          hi_run++;
        end
      end
    end
  end

  // Reference model: PSG byte encoding from register number and payload
  function automatic void model(input int a, input int ch, input int f, input int m,
                                output int b1, output int b2, output int nb);
    int r;
    r  = 2 * ch + a;
    b1 = 128 + r * 16 + (a != 0 ? m : f % 16);
    b2 = f / 16;
    nb = (a != 0) ? 1 : 2;
  endfunction

  task automatic send(input bit a, input logic [1:0] ch, input logic [9:0] f,
                      input logic [3:0] m, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_atten = a; req_chan = ch; req_freq = f; req_mag = m;
    @(negedge clk);
    req_valid = 1'b0;
    req_atten = 1'($urandom); req_chan = 2'($urandom); req_freq = 10'($urandom); req_mag = 4'($urandom);
    n = 0;
    while ((busy || !req_ready) && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    ok = (n < 200);
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (MREQ_N !== 1'b1 || WR_N !== 1'b1 || addr !== 16'h0000 || data !== 8'h00) begin
      bad++; $display("FAIL reset_bus: mreq=%b wr=%b addr=%h data=%h expected 1 1 0000 00", MREQ_N, WR_N, addr, data);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: ready=%b busy=%b done=%b err=%b expected 1 0 0 0", req_ready, busy, done, err);
    end
    lows = 0;
    repeat (20) begin @(negedge clk); if (MREQ_N !== 1'b1 || WR_N !== 1'b1) lows++; end
    total++;
    if (lows != 0 || bytes_q.size() != 0) begin
      bad++; $display("FAIL reset_idle: strobe_cycles=%0d bytes=%0d expected 0 0", lows, bytes_q.size());
    end
  endtask

  task automatic test_tone();
    int nb, nl, b0, d0, s0;
    bit ok;
    logic [7:0] b1, b2;
    nb = bytes_q.size(); nl = lens_q.size(); b0 = busy_total; d0 = done_total; s0 = stable_bad;
    send(1'b0, 2'd1, 10'h2A5, 4'($urandom), ok);
    total++;
    if (!ok) begin bad++; $display("FAIL tone_timeout: transfer did not finish within 200 cycles"); end
    total++;
    if (bytes_q.size() - nb != 2) begin
      bad++; $display("FAIL tone_count: bytes=%0d expected 2", bytes_q.size() - nb);
    end else begin
      b1 = bytes_q[nb]; b2 = bytes_q[nb+1];
      total++;
      if (b1 !== 8'hA5 || b2 !== 8'h2A) begin
        bad++; $display("FAIL tone_bytes: got %h %h expected a5 2a", b1, b2);
      end
      total++;
      if ({b2[5:0], b1[3:0]} !== 10'h2A5 || (3'b001 << b1[6:5]) !== 3'b010 || b1[4] !== 1'b0) begin
        bad++; $display("FAIL tone_decode: freq=%h chan=%0d atten=%b expected 2a5 1 0", {b2[5:0], b1[3:0]}, b1[6:5], b1[4]);
      end
      total++;
      if (gaps_q[nb+1] != G + 1) begin
        bad++; $display("FAIL tone_gap: got %0d expected %0d", gaps_q[nb+1], G + 1);
      end
    end
    total++;
    if (lens_q.size() - nl != 2 || (lens_q.size() - nl == 2 && (lens_q[nl] != S || lens_q[nl+1] != S))) begin
      bad++; $display("FAIL tone_strobe_len: strobes=%0d expected 2 each of %0d cycles", lens_q.size() - nl, S);
    end
    total++;
    if (busy_total - b0 != TONE_BUSY || done_total - d0 != 1) begin
      bad++; $display("FAIL tone_busy_done: busy=%0d done=%0d expected %0d 1", busy_total - b0, done_total - d0, TONE_BUSY);
    end
    total++;
    if (stable_bad != s0 || overlap_total != 0) begin
      bad++; $display("FAIL tone_stable: violations=%0d overlap=%0d expected 0 0", stable_bad - s0, overlap_total);
    end
  endtask

  task automatic test_atten();
    int nb, b0, d0;
    bit ok;
    nb = bytes_q.size(); b0 = busy_total; d0 = done_total;
    send(1'b1, 2'd2, 10'($urandom), 4'h7, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL atten_timeout: transfer did not finish within 200 cycles"); end
    total++;
    if (bytes_q.size() - nb != 1 || (bytes_q.size() - nb == 1 && bytes_q[nb] !== 8'hD7)) begin
      bad++; $display("FAIL atten_byte: count=%0d expected single byte d7", bytes_q.size() - nb);
    end
    total++;
    if (busy_total - b0 != ATT_BUSY || done_total - d0 != 1) begin
      bad++; $display("FAIL atten_busy_done: busy=%0d done=%0d expected %0d 1", busy_total - b0, done_total - d0, ATT_BUSY);
    end
  endtask

  task automatic test_illegal();
    int nb, b0, d0, e0;
    nb = bytes_q.size(); b0 = busy_total; d0 = done_total; e0 = err_total;
    @(negedge clk);
    req_valid = 1'b1; req_atten = 1'($urandom); req_chan = 2'd3; req_freq = 10'($urandom); req_mag = 4'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (err !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_err: err=%b ready=%b expected 1 1", err, req_ready);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_pulse: err=%b ready=%b expected 0 1", err, req_ready);
    end
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (bytes_q.size() != nb || busy_total != b0 || done_total != d0 || err_total - e0 != 1) begin
      bad++; $display("FAIL illegal_quiet: bytes=%0d busy=%0d done=%0d errs=%0d expected 0 0 0 1",
                      bytes_q.size() - nb, busy_total - b0, done_total - d0, err_total - e0);
    end
  endtask

  task automatic test_reset_mid();
    int nb, d0, n;
    bit ok;
    nb = bytes_q.size(); d0 = done_total;
    @(negedge clk);
    req_valid = 1'b1; req_atten = 1'b0; req_chan = 2'd0; req_freq = 10'h3FF;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (MREQ_N !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL midreset_strobe: first strobe not seen within 50 cycles"); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (MREQ_N !== 1'b1 || WR_N !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_immediate: mreq=%b wr=%b busy=%b expected 1 1 0", MREQ_N, WR_N, busy);
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (bytes_q.size() - nb != 1 || (bytes_q.size() - nb == 1 && bytes_q[nb] !== 8'h8F) || done_total != d0) begin
      bad++; $display("FAIL midreset_nobyte2: bytes=%0d done=%0d expected only 8f and no done",
                      bytes_q.size() - nb, done_total - d0);
    end
    nb = bytes_q.size();
    send(1'b1, 2'd1, 10'($urandom), 4'h5, ok);
    total++;
    if (!ok || bytes_q.size() - nb != 1 || (bytes_q.size() - nb == 1 && bytes_q[nb] !== 8'hB5)) begin
      bad++; $display("FAIL midreset_next: ok=%b count=%0d expected single byte b5", ok, bytes_q.size() - nb);
    end
  endtask

  task automatic test_back_to_back();
    int nb, nl, d0, b0, n;
    bit lens_ok;
    nb = bytes_q.size(); nl = lens_q.size(); d0 = done_total; b0 = busy_total;
    @(negedge clk);
    req_valid = 1'b1; req_atten = 1'b1; req_chan = 2'd0; req_mag = 4'hF; req_freq = 10'($urandom);
    @(negedge clk);
    req_atten = 1'b0; req_chan = 2'd2; req_freq = 10'h001; req_mag = 4'($urandom);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while ((busy || !req_ready) && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bytes_q.size() - nb != 3) begin
      bad++; $display("FAIL b2b_count: bytes=%0d expected 3", bytes_q.size() - nb);
    end else begin
      total++;
      if (bytes_q[nb] !== 8'h9F || bytes_q[nb+1] !== 8'hC1 || bytes_q[nb+2] !== 8'h00) begin
        bad++; $display("FAIL b2b_bytes: got %h %h %h expected 9f c1 00", bytes_q[nb], bytes_q[nb+1], bytes_q[nb+2]);
      end
      total++;
      if (gaps_q[nb+1] != G + 3 || gaps_q[nb+2] != G + 1) begin
        bad++; $display("FAIL b2b_spacing: gaps %0d %0d expected %0d %0d", gaps_q[nb+1], gaps_q[nb+2], G + 3, G + 1);
      end
    end
    lens_ok = (lens_q.size() - nl == 3);
    for (int i = nl; i < lens_q.size(); i++) if (lens_q[i] != S) lens_ok = 0;
    total++;
    if (!lens_ok || done_total - d0 != 2 || busy_total - b0 != ATT_BUSY + TONE_BUSY) begin
      bad++; $display("FAIL b2b_timing: strobes=%0d done=%0d busy=%0d expected 3 2 %0d",
                      lens_q.size() - nl, done_total - d0, busy_total - b0, ATT_BUSY + TONE_BUSY);
    end
  endtask

  task automatic test_random();
    int nb, d0, b0, e1, e2, cnt, a, ch, f, m;
    bit ok;
    for (int it = 0; it < 10; it++) begin
      a = int'($urandom_range(0, 1)); ch = int'($urandom_range(0, 2));
      f = int'($urandom_range(0, 1023)); m = int'($urandom_range(0, 15));
      model(a, ch, f, m, e1, e2, cnt);
      nb = bytes_q.size(); d0 = done_total; b0 = busy_total;
      send(1'(a), 2'(ch), 10'(f), 4'(m), ok);
      total++;
      if (!ok || bytes_q.size() - nb != cnt) begin
        bad++; $display("FAIL rand_count[%0d]: ok=%b bytes=%0d expected %0d", it, ok, bytes_q.size() - nb, cnt);
      end else begin
        total++;
        if (int'(bytes_q[nb]) != e1 || (cnt == 2 && int'(bytes_q[nb+1]) != e2)) begin
          bad++; $display("FAIL rand_bytes[%0d]: got %h %h expected %h %h", it, bytes_q[nb],
                          (cnt == 2) ? bytes_q[nb+1] : 8'h00, e1, (cnt == 2) ? e2 : 0);
        end
      end
      total++;
      if (done_total - d0 != 1 || busy_total - b0 != ((a != 0) ? ATT_BUSY : TONE_BUSY)) begin
        bad++; $display("FAIL rand_timing[%0d]: done=%0d busy=%0d expected 1 %0d", it, done_total - d0,
                        busy_total - b0, (a != 0) ? ATT_BUSY : TONE_BUSY);
      end
    end
    total++;
    if (stable_bad != 0 || overlap_total != 0) begin
      bad++; $display("FAIL bus_rules: violations=%0d overlap=%0d expected 0 0", stable_bad, overlap_total);
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_atten();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
